// File: rtl/lc3_reg_file.sv
// lc3_reg_file: LC-3 general register file.
// DEPTH x WIDTH storage with two read ports (SR1, SR2) and one write port (DR).
// Optional write-to-read bypass and optional registered read data.
// Also keeps a per-register busy scoreboard and the NZP condition codes.
//
// Strobe semantics: there is no valid/ready handshake on any port. wr_en and
// rsv_en are single-cycle strobes that are always accepted at the next rising
// edge; nothing in this block can stall them.
module lc3_reg_file #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [AW-1:0]    sr1_addr,
    input  logic [AW-1:0]    sr2_addr,
    output logic [WIDTH-1:0] sr1_data,
    output logic [WIDTH-1:0] sr2_data,
    output logic             sr1_busy,
    output logic             sr2_busy,

    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_setcc,

    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,

    output logic [2:0]       nzp,
    output logic             any_busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [2:0]       nzp_q;

    // Condition codes of a value: exactly one of N, Z, P is set.
    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        logic is_neg;
        logic is_zero;
        is_neg  = v[WIDTH-1];
        is_zero = (v == '0);
        return {is_neg, is_zero, ~is_neg & ~is_zero};
    endfunction

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------

    // Write port: store wr_data into the destination register on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------

    // Next busy vector: a write retires the register, a reserve claims it.
    // The reserve is applied last so that a same-edge write and reserve of
    // one register leaves it busy; the reservation belongs to a newer
    // instruction than the one whose result is being written.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Busy bits are plain state updated from busy_next every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Stored busy bits only; a same-cycle reserve shows up after the edge.
    assign any_busy = |busy;

    // ------------------------------------------------------------------
    // Condition codes
    // ------------------------------------------------------------------

    // NZP follows wr_data only on flagged writes; reset value is Z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_q <= 3'b010;
        end else if (wr_en && wr_setcc) begin
            nzp_q <= cc_of(wr_data);
        end
    end

    assign nzp = nzp_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic             rd1_hit;
    logic             rd2_hit;
    logic [WIDTH-1:0] rd1_data;
    logic [WIDTH-1:0] rd2_data;
    logic             rd1_busy;
    logic             rd2_busy;

    // Bypass-resolved read values. The bypass is suppressed while reset is
    // asserted so an in-flight write can never leak onto the read ports.
    always_comb begin
        rd1_hit  = (BYPASS != 0) && rst_n && wr_en && (sr1_addr == wr_addr);
        rd2_hit  = (BYPASS != 0) && rst_n && wr_en && (sr2_addr == wr_addr);
        rd1_data = rd1_hit ? wr_data : regs[sr1_addr];
        rd2_data = rd2_hit ? wr_data : regs[sr2_addr];
        rd1_busy = rd1_hit ? 1'b0    : busy[sr1_addr];
        rd2_busy = rd2_hit ? 1'b0    : busy[sr2_addr];
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [WIDTH-1:0] sr1_data_q;
            logic [WIDTH-1:0] sr2_data_q;
            logic             sr1_busy_q;
            logic             sr2_busy_q;

            // Capture the bypass-resolved read values: one cycle of latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr1_data_q <= '0;
                    sr2_data_q <= '0;
                    sr1_busy_q <= 1'b0;
                    sr2_busy_q <= 1'b0;
                end else begin
                    sr1_data_q <= rd1_data;
                    sr2_data_q <= rd2_data;
                    sr1_busy_q <= rd1_busy;
                    sr2_busy_q <= rd2_busy;
                end
            end

            assign sr1_data = sr1_data_q;
            assign sr2_data = sr2_data_q;
            assign sr1_busy = sr1_busy_q;
            assign sr2_busy = sr2_busy_q;
        end else begin : g_read_comb
            assign sr1_data = rd1_data;
            assign sr2_data = rd2_data;
            assign sr1_busy = rd1_busy;
            assign sr2_busy = rd2_busy;
        end
    endgenerate

endmodule

// File: doc/lc3_reg_file.md
# lc3_reg_file

Parametrised multi-port register file for the LC-3 datapath, the successor to the fixed 8×16 read mux. It holds DEPTH general registers of WIDTH bits and provides two read ports (SR1, SR2), one write port (DR) with optional write-to-read bypass and optionally registered read data. It also holds a per-register busy scoreboard for the sequencer and an NZP condition-code register updated on flagged writes.

## Interface
- WIDTH, 16, data width in bits (≥2)
- DEPTH, 8, number of registers (power of two, ≥2)
- AW, $clog2(DEPTH), address width
- BYPASS, 1, 1 = read of a register being written this cycle returns the new data
- READ_REG, 0, 0 = combinational read data; 1 = read data registered (1-cycle latency)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- sr1_addr  in  AW  read port 1 address
- sr2_addr  in  AW  read port 2 address
- sr1_data  out  WIDTH  read port 1 data
- sr2_data  out  WIDTH  read port 2 data
- sr1_busy  out  1  busy bit of the register addressed by sr1 (same latency as sr1_data)
- sr2_busy  out  1  busy bit of the register addressed by sr2
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address (DR)
- wr_data  in  WIDTH  write data
- wr_setcc  in  1  when set with wr_en, update NZP from wr_data
- rsv_en  in  1  reserve strobe: mark rsv_addr busy
- rsv_addr  in  AW  register to reserve
- nzp  out  3  condition codes {N,Z,P}
- any_busy  out  1  OR of all busy bits

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, nzp = 3'b010, sr*_data = 0, sr*_busy = 0, any_busy = 0. Any in-flight write or reserve is discarded; state holds its reset values while rst_n is low.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data, and busy[wr_addr] is cleared.
- Reserve: on the rising edge with rsv_en=1, busy[rsv_addr] <= 1.
- Simultaneous write and reserve to the same address: data is written and the busy bit ends at 1 (the reservation belongs to a newer instruction). Different addresses: both take effect.
- Write to a non-busy register is legal and leaves its busy bit at 0.
- Condition codes: on wr_en & wr_setcc, nzp <= {wr_data[WIDTH-1], wr_data==0, ~wr_data[WIDTH-1] & (wr_data!=0)}. Exactly one bit is always set. nzp is otherwise held. wr_setcc without wr_en is ignored.
- Read, BYPASS=1: if wr_en and sr_addr==wr_addr, the port returns wr_data and busy=0; otherwise it returns reg[sr_addr] and busy[sr_addr]. A same-cycle reserve does not affect the busy bit returned in that cycle.
- Read, BYPASS=0: the port returns stored contents only; new data becomes visible the cycle after the write edge.
- Both read ports may address the same register, including the write address.
- any_busy reflects stored busy bits (registered state, no bypass).

## Timing
- READ_REG=0: sr*_data/sr*_busy are combinational from addresses, storage and (if BYPASS) write inputs. Latency is 0 cycles.
- READ_REG=1: the bypass-resolved value is captured at the edge, so data appears one cycle after the address is presented. With BYPASS=1, a write at edge N and a read addressed in the cycle before edge N return the new data after edge N.
- Write-to-storage latency: 1 edge. nzp and any_busy update 1 edge after the strobe.
- No handshake stalls; every strobe is accepted every cycle.

## Test plan
- Reset: drive wr_en with 16'hFFFF to R3 and assert rst_n low mid-cycle -> immediately all reads 0, nzp=3'b010, any_busy=0; after release, R3 reads 0.
- Write/read all: write R0..R7 = 16'h1000+i, then sweep sr1/sr2 over all addresses -> exact values; the same address on both ports gives identical data.
- Bypass: BYPASS=1, READ_REG=0; write R5=16'hBEEF while sr1_addr=5 -> sr1_data=16'hBEEF in the same cycle. BYPASS=0 -> old value, then 16'hBEEF next cycle.
- Scoreboard: reserve R2 -> sr1_busy=1 and any_busy=1. Write R2 together with a reserve of R2 -> busy stays 1. A later write of R2 alone -> busy 0, any_busy 0.
- NZP: setcc writes of 16'h8000, 16'h0000 and 16'h0001 -> nzp=100, 010, 001. A write of 16'h8000 with wr_setcc=0 -> nzp unchanged.
- Registered read: READ_REG=1; change sr2_addr from 1 to 4 -> sr2_data shows R4 one cycle later, never in the same cycle.
